ag_dm_pipe_reg: RTL and testbench
=================================

Name: ag_dm_pipe_reg

Overview:
- Parametrised pipeline register between the address-generation (AG) stage and the data-memory/cache (DM) stage of the superscalar core.
- Carries LANES parallel memory slots per bundle.
- Adds valid/ready flow control with a 2-entry skid buffer, so a cache miss can stall DM without a combinational ready path back into AG.
- Adds flush, and a store write-enable that is a clean synchronous qualifier instead of a timed pulse.
- Exports a saturating stall-cycle counter for performance monitoring.

Parameters:
- LANES, 2, memory slots per bundle (1..4).
- AW, 32, address width.
- DW, 32, store-data and instruction width.
- TAGW, 32, load instruction-number (tag) width.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held and incoming bundles this cycle.
- ag_valid  in  1  AG presents a bundle.
- ag_ready  out  1  block can accept a bundle; registered.
- ag_lane_vld  in  LANES  per-lane slot occupied.
- ag_we  in  LANES  per-lane store flag.
- ag_ld_addr  in  LANES*AW  load addresses, lane l at [l*AW +: AW].
- ag_str_addr  in  LANES*AW  store addresses.
- ag_store_data  in  LANES*DW  store data.
- ag_ld_instr  in  LANES*DW  load instruction words.
- ag_ld_instr_no  in  LANES*TAGW  load tags.
- dm_valid  out  1  bundle presented to DM.
- dm_ready  in  1  DM/cache consumes bundle; low on miss.
- dm_lane_vld  out  LANES  per-lane valid.
- dm_we  out  LANES  store enable.
- dm_ld_addr, dm_str_addr, dm_write_data, dm_ld_instr, dm_ld_instr_no  out  same widths as AG counterparts.
- stall_cnt  out  CNTW  saturating count of cycles with dm_valid=1 and dm_ready=0.

Behaviour:
- Storage: main register M (drives dm_*) and skid register S, each with its own valid bit. Payload is all per-lane fields.
- Reset (rst_n=0 at edge):
  - M.v=0, S.v=0, ag_ready=1, stall_cnt=0.
  - All dm_* payload outputs are 0, dm_we=0, dm_lane_vld=0.
  - Payload registers are also cleared.
- Accept condition: accept = ag_valid & ag_ready. Deliver condition: deliver = dm_valid & dm_ready.
- Transitions per edge (flush=0):
  - S empty, M empty: accept loads M.
  - M valid, deliver, no accept: M empties.
  - M valid, deliver, accept: M takes the new bundle.
  - M valid, no deliver, accept: the new bundle goes to S. S.v=1 and ag_ready falls next cycle.
  - S valid, deliver: M takes S, S empties, ag_ready rises next cycle. Accept is impossible while S is full.
- ag_ready = ~S.v, registered. It never depends combinationally on dm_ready.
- Latency: 1 cycle from accept to dm_valid when the block is empty. Throughput is 1 bundle/cycle while dm_ready=1.
- Outputs:
  - dm_valid = M.v.
  - dm_lane_vld = M.lane_vld & {LANES{M.v}}.
  - dm_we = M.we & M.lane_vld & {LANES{M.v}}. It is combinational from registers.
  - dm_we is asserted for every cycle the bundle is held. DM writes only on the cycle with dm_ready=1, which guarantees exactly one write per store.
- Ordering: strict FIFO order, no reordering between M and S. All lanes of a bundle move together.
- Flush:
  - flush=1 at an edge forces M.v=0 and S.v=0, and ignores accept that cycle.
  - ag_ready is 1 next cycle.
  - Payload is don't-care but dm_we must be 0.
  - Flush has priority over accept/deliver.
  - A bundle delivered in the flush cycle still counts as consumed by DM.
- Reset overrides flush.
- Bubbles: ag_valid=1 with ag_lane_vld=0 is a legal empty bundle. It is passed through with dm_valid=1 and all lanes invalid.
- stall_cnt:
  - Increments when M.v & ~dm_ready, and saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- No X propagation: payload registers are written only on load, otherwise they hold.

Decomposition:
- Shared package core_mem_pkg holds:
  - constants LANES_MAX=4 and the default AW/DW/TAGW;
  - typedef mem_slot_t (lane_vld, we, ld_addr, str_addr, store_data, ld_instr, ld_instr_no) per lane;
  - typedef mem_bundle_t as an array of slots.
- One natural sub-module, pipe_slot_reg: a payload register with load-enable and synchronous clear, instantiated twice (M, S).
- The control FSM, with states EMPTY / ONE / FULL as {S.v,M.v}, stays in the top level.

Test Plan:
- Reset then stream: with LANES=2, send 4 bundles back-to-back with dm_ready=1 (lane0 ld_addr 0x100, 0x104, 0x108, 0x10C) → dm_valid 1 cycle after each accept, addresses in order, ag_ready constantly 1.
- Stall/skid: hold dm_ready=0 after bundle A is in M and present B → B lands in S, ag_ready=0 next cycle. Release dm_ready for 2 cycles → A then B delivered, ag_ready returns to 1, stall_cnt equals the number of stall cycles.
- Store single-write: lane1 store to 0x2000 data 0xDEADBEEF with dm_ready low 3 cycles then high → dm_we[1]=1 throughout the hold. The bench memory model records exactly one write, at the dm_ready=1 cycle.
- Flush with both entries full plus ag_valid=1 → next cycle dm_valid=0, dm_we=0, ag_ready=1; the incoming bundle is not captured.
- Mid-operation reset: rst_n=0 for 1 cycle while S is full and stall_cnt=5 → all outputs 0, ag_ready=1, stall_cnt=0, and no stale bundle appears afterwards.
- Saturation: CNTW=4, dm_ready=0 for 20 cycles with M valid → stall_cnt stops at 15.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the AG -> DM memory pipeline.
// A slot is one memory lane; a bundle is the set of lanes issued together.
package core_mem_pkg;

    localparam int LANES_MAX = 4;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int TAGW_DEF  = 32;

    typedef struct packed {
        logic                lane_vld;
        logic                we;
        logic [AW_DEF-1:0]   ld_addr;
        logic [AW_DEF-1:0]   str_addr;
        logic [DW_DEF-1:0]   store_data;
        logic [DW_DEF-1:0]   ld_instr;
        logic [TAGW_DEF-1:0] ld_instr_no;
    } mem_slot_t;

    typedef mem_slot_t [LANES_MAX-1:0] mem_bundle_t;

    // Encoded as {S.v, M.v}; 2'b10 cannot occur because S only fills behind M.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } pipe_state_e;

    // Flattened bit width of one slot for arbitrary field widths.
    function automatic int slot_width(input int aw, input int dw, input int tagw);
        return 2 + 2 * aw + 2 * dw + tagw;
    endfunction

endpackage

// File: rtl/pipe_slot_reg.sv
// Payload register with load-enable and synchronous clear; clear wins over load.
module pipe_slot_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ag_dm_pipe_reg.sv
// AG -> DM pipeline register: main register M feeds DM, skid register S absorbs
// one bundle when DM stalls, so ag_ready is purely registered.
module ag_dm_pipe_reg
    import core_mem_pkg::*;
#(
    parameter int LANES = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int TAGW  = TAGW_DEF,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ag_valid,
    output logic                  ag_ready,
    input  logic [LANES-1:0]      ag_lane_vld,
    input  logic [LANES-1:0]      ag_we,
    input  logic [LANES*AW-1:0]   ag_ld_addr,
    input  logic [LANES*AW-1:0]   ag_str_addr,
    input  logic [LANES*DW-1:0]   ag_store_data,
    input  logic [LANES*DW-1:0]   ag_ld_instr,
    input  logic [LANES*TAGW-1:0] ag_ld_instr_no,
    output logic                  dm_valid,
    input  logic                  dm_ready,
    output logic [LANES-1:0]      dm_lane_vld,
    output logic [LANES-1:0]      dm_we,
    output logic [LANES*AW-1:0]   dm_ld_addr,
    output logic [LANES*AW-1:0]   dm_str_addr,
    output logic [LANES*DW-1:0]   dm_write_data,
    output logic [LANES*DW-1:0]   dm_ld_instr,
    output logic [LANES*TAGW-1:0] dm_ld_instr_no,
    output logic [CNTW-1:0]       stall_cnt
);

    localparam int SW = slot_width(AW, DW, TAGW);
    localparam int BW = LANES * SW;

    pipe_state_e     state_q, state_d;
    logic            ag_ready_q, ag_ready_d;
    logic [CNTW-1:0] stall_q, stall_d;

    logic            m_v;
    logic            accept;
    logic            deliver;
    logic            m_load;
    logic            s_load;
    logic            m_from_s;
    logic [BW-1:0]   ag_bundle;
    logic [BW-1:0]   m_din;
    logic [BW-1:0]   m_bundle;
    logic [BW-1:0]   s_bundle;
    logic [LANES-1:0] m_lane_vld;
    logic [LANES-1:0] m_we;

    assign m_v     = (state_q == ONE) || (state_q == FULL);
    assign accept  = ag_valid & ag_ready_q;
    assign deliver = m_v & dm_ready;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        s_load   = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        m_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (deliver) begin
                        if (accept) begin
                            m_load = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (accept) begin
                        s_load  = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    // ag_ready is low here, so only the S -> M move can happen.
                    if (deliver) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        state_d  = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        ag_ready_d = (state_d != FULL);
    end

    always_comb begin
        stall_d = stall_q;
        if (m_v && !dm_ready && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ag_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            ag_ready_q <= ag_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign m_din = m_from_s ? s_bundle : ag_bundle;

    pipe_slot_reg #(.W(BW)) u_m_reg (
        .clk  (clk),
        .clr  (~rst_n),
        .load (m_load),
        .d    (m_din),
        .q    (m_bundle)
    );

    pipe_slot_reg #(.W(BW)) u_s_reg (
        .clk  (clk),
        .clr  (~rst_n),
        .load (s_load),
        .d    (ag_bundle),
        .q    (s_bundle)
    );

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign ag_bundle[l*SW +: SW] = {ag_lane_vld[l], ag_we[l],
                                        ag_ld_addr[l*AW +: AW], ag_str_addr[l*AW +: AW],
                                        ag_store_data[l*DW +: DW], ag_ld_instr[l*DW +: DW],
                                        ag_ld_instr_no[l*TAGW +: TAGW]};
        assign {m_lane_vld[l], m_we[l],
                dm_ld_addr[l*AW +: AW], dm_str_addr[l*AW +: AW],
                dm_write_data[l*DW +: DW], dm_ld_instr[l*DW +: DW],
                dm_ld_instr_no[l*TAGW +: TAGW]} = m_bundle[l*SW +: SW];
    end

    // Stores stay asserted while held; DM commits only on its dm_ready cycle.
    assign dm_valid    = m_v;
    assign dm_lane_vld = m_lane_vld & {LANES{m_v}};
    assign dm_we       = m_we & dm_lane_vld;
    assign ag_ready    = ag_ready_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_ag_dm_pipe_reg.sv
// Scoreboard bench for ag_dm_pipe_reg: driver queues expected bundles on accept,
// a negedge monitor pops and compares on every DM handshake.
module tb_ag_dm_pipe_reg;

    localparam int L  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [L-1:0]    vld;
        logic [L-1:0]    we;
        logic [L*AW-1:0] ld;
        logic [L*AW-1:0] st;
        logic [L*DW-1:0] sd;
        logic [L*DW-1:0] ins;
        logic [L*TW-1:0] tag;
    } bnd_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            ag_valid = 1'b0;
    logic            ag_ready;
    logic [L-1:0]    ag_lane_vld = '0;
    logic [L-1:0]    ag_we = '0;
    logic [L*AW-1:0] ag_ld_addr = '0;
    logic [L*AW-1:0] ag_str_addr = '0;
    logic [L*DW-1:0] ag_store_data = '0;
    logic [L*DW-1:0] ag_ld_instr = '0;
    logic [L*TW-1:0] ag_ld_instr_no = '0;
    logic            dm_valid;
    logic            dm_ready = 1'b0;
    logic [L-1:0]    dm_lane_vld;
    logic [L-1:0]    dm_we;
    logic [L*AW-1:0] dm_ld_addr;
    logic [L*AW-1:0] dm_str_addr;
    logic [L*DW-1:0] dm_write_data;
    logic [L*DW-1:0] dm_ld_instr;
    logic [L*TW-1:0] dm_ld_instr_no;
    logic [CW-1:0]   stall_cnt;

    bnd_t            exp_q[$];
    int              n_chk = 0;
    int              n_pass = 0;
    int              wr_cnt [logic [31:0]];
    logic [31:0]     wr_data [logic [31:0]];
    logic [CW-1:0]   stall_mdl = '0;
    bit              mon_en = 1'b0;

    ag_dm_pipe_reg #(.LANES(L), .AW(AW), .DW(DW), .TAGW(TW), .CNTW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .ag_valid       (ag_valid),
        .ag_ready       (ag_ready),
        .ag_lane_vld    (ag_lane_vld),
        .ag_we          (ag_we),
        .ag_ld_addr     (ag_ld_addr),
        .ag_str_addr    (ag_str_addr),
        .ag_store_data  (ag_store_data),
        .ag_ld_instr    (ag_ld_instr),
        .ag_ld_instr_no (ag_ld_instr_no),
        .dm_valid       (dm_valid),
        .dm_ready       (dm_ready),
        .dm_lane_vld    (dm_lane_vld),
        .dm_we          (dm_we),
        .dm_ld_addr     (dm_ld_addr),
        .dm_str_addr    (dm_str_addr),
        .dm_write_data  (dm_write_data),
        .dm_ld_instr    (dm_ld_instr),
        .dm_ld_instr_no (dm_ld_instr_no),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bnd_t mk(input logic [31:0] a, input logic [1:0] vld, input logic [1:0] we);
        bnd_t b;
        b.vld = vld;
        b.we  = we;
        b.ld  = {a + 32'h1000, a};
        b.st  = {a + 32'h2004, a + 32'h2000};
        b.sd  = {~a, a ^ 32'h5a5a5a5a};
        b.ins = {a | 32'h13, a | 32'h3};
        b.tag = {a + 32'h1, a};
        return b;
    endfunction

    task automatic drive(input bnd_t b);
        ag_lane_vld    = b.vld;
        ag_we          = b.we;
        ag_ld_addr     = b.ld;
        ag_str_addr    = b.st;
        ag_store_data  = b.sd;
        ag_ld_instr    = b.ins;
        ag_ld_instr_no = b.tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents b until accepted; optionally checks dm_valid on the first cycle.
    task automatic send(input bnd_t b, input bit chk_dv, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        drive(b);
        ag_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (chk_dv && i == 0) chk("latency_dm_valid", dm_valid, 1);
            if (ag_ready) begin
                exp_q.push_back(b);
                ok = 1'b1;
            end else begin
                waited++;
            end
            tick();
        end
        ag_valid = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    // Monitor: scoreboard compare, memory model, stall-counter model, output gating.
    always @(negedge clk) begin
        bnd_t act;
        bnd_t e;
        logic [31:0] a;
        if (mon_en) begin
            act = {dm_lane_vld, dm_we, dm_ld_addr, dm_str_addr, dm_write_data, dm_ld_instr, dm_ld_instr_no};
            chk("stall_cnt_model", stall_cnt, stall_mdl);
            chk("we_within_lane_vld", dm_we & ~dm_lane_vld, 0);
            if (!dm_valid) chk("idle_lanes_zero", {dm_lane_vld, dm_we}, 0);
            if (rst_n && dm_valid && dm_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bundle", dm_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    e.we = e.we & e.vld;
                    chk("bundle", act, e);
                    for (int l = 0; l < L; l++) begin
                        if (dm_we[l]) begin
                            a = dm_str_addr[l*AW +: AW];
                            if (wr_cnt.exists(a)) wr_cnt[a] = wr_cnt[a] + 1;
                            else wr_cnt[a] = 1;
                            wr_data[a] = dm_write_data[l*DW +: DW];
                        end
                    end
                end
            end
            if (!rst_n) stall_mdl = '0;
            else if (dm_valid && !dm_ready && stall_mdl != {CW{1'b1}}) stall_mdl = stall_mdl + 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        bnd_t b;
        int   w;
        int   cnt;

        // Reset
        dm_ready = 1'b1;
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_dm_valid", dm_valid, 0);
        chk("reset_ag_ready", ag_ready, 1);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_payload", {dm_ld_addr, dm_write_data, dm_we}, 0);
        tick();

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            send(mk(32'h100 + 32'(4 * i), 2'b11, 2'b00), i > 0, w);
            chk("stream_no_wait", w, 0);
        end
        @(negedge clk);
        chk("stream_last_valid", dm_valid, 1);
        chk("stream_last_addr", dm_ld_addr[31:0], 32'h10C);
        tick();
        @(negedge clk);
        chk("stream_drained", exp_q.size(), 0);
        tick();

        // Stall / skid
        dm_ready = 1'b0;
        send(mk(32'h500, 2'b11, 2'b00), 0, w);
        send(mk(32'h600, 2'b11, 2'b00), 0, w);
        @(negedge clk);
        chk("skid_ready_low", ag_ready, 0);
        chk("skid_head_addr", dm_ld_addr[31:0], 32'h500);
        tick();
        dm_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("skid_ready_back", ag_ready, 1);
        chk("skid_second_addr", dm_ld_addr[31:0], 32'h600);
        tick();
        @(negedge clk);
        chk("skid_stall_cnt", stall_cnt, 2);
        chk("skid_drained", exp_q.size(), 0);
        tick();

        // Store held 3 stall cycles then written once
        dm_ready = 1'b0;
        b = mk(32'h300, 2'b10, 2'b10);
        b.st[63:32] = 32'h2000;
        b.sd[63:32] = 32'hDEADBEEF;
        send(b, 0, w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("store_we_hold", dm_we, 2'b10);
            tick();
        end
        dm_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        cnt = wr_cnt.exists(32'h2000) ? wr_cnt[32'h2000] : 0;
        chk("store_write_count", cnt, 1);
        chk("store_write_data", wr_data.exists(32'h2000) ? wr_data[32'h2000] : 32'h0, 32'hDEADBEEF);
        tick();

        // Empty bundle passes through
        send(mk(32'h400, 2'b00, 2'b11), 0, w);
        @(negedge clk);
        chk("bubble_valid", dm_valid, 1);
        chk("bubble_lanes", {dm_lane_vld, dm_we}, 0);
        tick();
        tick();

        // Flush with M only: incoming accept is ignored
        dm_ready = 1'b0;
        send(mk(32'h700, 2'b11, 2'b01), 0, w);
        drive(mk(32'h780, 2'b11, 2'b11));
        ag_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ag_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_accept_ignored", dm_valid, 0);
        chk("flush1_ready", ag_ready, 1);
        tick();

        // Flush with M and S full plus incoming bundle
        send(mk(32'h800, 2'b11, 2'b01), 0, w);
        send(mk(32'h900, 2'b11, 2'b10), 0, w);
        @(negedge clk);
        chk("flush_pre_full", ag_ready, 0);
        tick();
        drive(mk(32'hA00, 2'b11, 2'b11));
        ag_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ag_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_dm_valid", dm_valid, 0);
        chk("flush_dm_we", dm_we, 0);
        chk("flush_ready", ag_ready, 1);
        tick();
        dm_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("flush_no_capture", dm_valid, 0);
        tick();

        // Mid-operation reset with S full and stall_cnt = 5
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dm_ready = 1'b0;
        send(mk(32'hB00, 2'b11, 2'b11), 0, w);
        send(mk(32'hC00, 2'b11, 2'b11), 0, w);
        repeat (4) tick();
        @(negedge clk);
        chk("pre_reset_stall", stall_cnt, 5);
        chk("pre_reset_full", ag_ready, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midreset_dm_valid", dm_valid, 0);
        chk("midreset_ag_ready", ag_ready, 1);
        chk("midreset_stall", stall_cnt, 0);
        chk("midreset_outputs", {dm_lane_vld, dm_we, dm_ld_addr, dm_str_addr, dm_write_data, dm_ld_instr, dm_ld_instr_no}, 0);
        tick();
        dm_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("midreset_no_stale", dm_valid, 0);
        tick();

        // Stall counter saturation
        dm_ready = 1'b0;
        send(mk(32'hD00, 2'b01, 2'b00), 0, w);
        repeat (20) tick();
        @(negedge clk);
        chk("stall_saturate", stall_cnt, 15);
        tick();
        dm_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_stall_held", stall_cnt, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
